// File: rtl/jtframe_rom_pkg.sv
// Shared constants, arbiter state encoding and byte-lane helper for the ROM read arbiter.
package jtframe_rom_pkg;

    localparam int unsigned SDRAM_AW = 22;
    localparam int unsigned DATA_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    // 16-bit slots see the whole word; 8-bit slots get one byte on the low lane
    function automatic logic [DATA_W-1:0] byte_sel(
        input logic [DATA_W-1:0] data,
        input logic              is16,
        input logic              hi
    );
        if (is16) begin
            return data;
        end
        return {8'h00, (hi ? data[15:8] : data[7:0])};
    endfunction

endpackage

// File: rtl/jtframe_rom_slotc.sv
// One-entry read cache for a single slot: hit compare, byte select and pending flag.
module jtframe_rom_slotc
    import jtframe_rom_pkg::*;
#(
    parameter int unsigned AW   = 18,
    parameter bit          DW16 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic              cs,
    input  logic [AW-1:0]     addr,
    input  logic              fill,
    input  logic [AW-1:0]     fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    output logic [DATA_W-1:0] dout,
    output logic              ok,
    output logic              req_c,
    output logic [AW-1:0]     word_c
);

    logic              valid;
    logic              pending;
    logic [AW-1:0]     cache_addr;
    logic [DATA_W-1:0] cache_data;
    logic              hit_c;
    logic              byp_c;

    // Word address, hit against the cache, hit against the word being written this cycle
    always_comb begin
        word_c = DW16 ? addr : AW'(addr >> 1);
        hit_c  = valid && (cache_addr == word_c);
        byp_c  = fill && (fill_addr == word_c);
        // An active miss asks for service; an abandoned miss still completes its pending fetch
        req_c  = !downloading && (cs ? !hit_c : pending);
    end

    // Cache contents, pending flag and registered data/ok
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= 1'b0;
            pending    <= 1'b0;
            cache_addr <= '0;
            cache_data <= '0;
            ok         <= 1'b0;
            dout       <= '0;
        end else if (downloading) begin
            valid      <= 1'b0;
            pending    <= 1'b0;
            ok         <= 1'b0;
        end else begin
            if (fill) begin
                valid      <= 1'b1;
                cache_addr <= fill_addr;
                cache_data <= fill_data;
                pending    <= 1'b0;
            end else if (cs && !hit_c) begin
                pending    <= 1'b1;
            end
            ok <= cs && (byp_c || hit_c);
            if (cs && byp_c) begin
                dout <= byte_sel(fill_data, DW16, addr[0]);
            end else if (cs && hit_c) begin
                dout <= byte_sel(cache_data, DW16, addr[0]);
            end
        end
    end

endmodule

// File: rtl/jtframe_rom_arbn.sv
// N-slot ROM read arbiter: per-slot caches sharing one SDRAM read port, one transaction at a time.
module jtframe_rom_arbn
    import jtframe_rom_pkg::*;
#(
    parameter int unsigned                  SLOTS  = 4,
    parameter int unsigned                  AW     = 18,
    parameter logic [SLOTS-1:0]             DW16   = '0,
    parameter logic [SLOTS*SDRAM_AW-1:0]    OFFSET = '0,
    parameter int unsigned                  RR     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     downloading,
    input  logic [SLOTS-1:0]         slot_cs,
    input  logic [SLOTS*AW-1:0]      slot_addr,
    output logic [SLOTS*DATA_W-1:0]  slot_dout,
    output logic [SLOTS-1:0]         slot_ok,
    output logic                     sdram_req,
    input  logic                     sdram_ack,
    output logic [SDRAM_AW-1:0]      sdram_addr,
    input  logic                     data_dst,
    input  logic                     data_rdy,
    input  logic [DATA_W-1:0]        data_read
);

    localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    arb_state_t            state;
    logic [IW-1:0]         grant;
    logic [IW-1:0]         last;
    logic [AW-1:0]         wlat;
    logic [SLOTS-1:0]      req_c;
    logic [SLOTS-1:0]      fill_c;
    logic [SLOTS*AW-1:0]   word_c;
    logic [IW-1:0]         gsel_c;
    logic [IW-1:0]         idx_c;
    logic                  gany_c;
    logic [AW-1:0]         gword_c;
    logic [SDRAM_AW-1:0]   goff_c;
    logic                  dst_unused;

    // Data phase start is a monitor-only strobe
    assign dst_unused = data_dst;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        // Only the granted slot takes the returned word, and only while the fetch is still live
        assign fill_c[i] = (state == ST_WAIT) && data_rdy && !downloading && (grant == IW'(i));

        jtframe_rom_slotc #(
            .AW   (AW),
            .DW16 (DW16[i])
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .downloading (downloading),
            .cs          (slot_cs[i]),
            .addr        (slot_addr[i*AW +: AW]),
            .fill        (fill_c[i]),
            .fill_addr   (wlat),
            .fill_data   (data_read),
            .dout        (slot_dout[i*DATA_W +: DATA_W]),
            .ok          (slot_ok[i]),
            .req_c       (req_c[i]),
            .word_c      (word_c[i*AW +: AW])
        );
    end

    // Pick the next slot to serve: highest index, or first after the last grant when rotating
    always_comb begin
        gsel_c  = '0;
        gany_c  = 1'b0;
        idx_c   = '0;
        gword_c = '0;
        goff_c  = '0;
        if (RR == 0) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                if (req_c[IW'(i)]) begin
                    gsel_c = IW'(i);
                    gany_c = 1'b1;
                end
            end
        end else begin
            // Walk farthest-first so the nearest requester after the last grant wins
            for (int unsigned k = SLOTS; k >= 1; k--) begin
                idx_c = IW'((32'(last) + k) % SLOTS);
                if (req_c[idx_c]) begin
                    gsel_c = idx_c;
                    gany_c = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (gsel_c == IW'(i)) begin
                gword_c = word_c[i*AW +: AW];
                goff_c  = OFFSET[i*SDRAM_AW +: SDRAM_AW];
            end
        end
    end

    // SDRAM transaction sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            grant      <= '0;
            last       <= '0;
            wlat       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sdram_req <= 1'b0;
                    if (!downloading && gany_c) begin
                        state      <= ST_REQ;
                        sdram_req  <= 1'b1;
                        grant      <= gsel_c;
                        last       <= gsel_c;
                        wlat       <= gword_c;
                        sdram_addr <= goff_c + SDRAM_AW'(gword_c);
                    end
                end
                ST_REQ: begin
                    if (downloading) begin
                        state     <= ST_IDLE;
                        sdram_req <= 1'b0;
                    end else if (sdram_ack) begin
                        state     <= ST_WAIT;
                        sdram_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    sdram_req <= 1'b0;
                    if (downloading || data_rdy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    sdram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
